// File: rtl/acc_responder.sv
// Accelerator endpoint: accepts id-tagged integer ops on the q-channel, runs them through a
// fixed-latency pipeline and returns results in order through a response FIFO on the p-channel.
module acc_responder #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 4,
    parameter int IdWidth   = 4,
    parameter int Latency   = 2,
    parameter int FifoDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] q_addr_i,
    input  logic [IdWidth-1:0]   q_id_i,
    input  logic [31:0]          q_data_op_i,
    input  logic [DataWidth-1:0] q_data_arga_i,
    input  logic [DataWidth-1:0] q_data_argb_i,
    input  logic [DataWidth-1:0] q_data_argc_i,
    input  logic                 q_valid_i,
    output logic                 q_ready_o,
    output logic [DataWidth-1:0] p_data0_o,
    output logic [DataWidth-1:0] p_data1_o,
    output logic                 p_dual_writeback_o,
    output logic [IdWidth-1:0]   p_id_o,
    output logic [4:0]           p_rd_o,
    output logic                 p_error_o,
    output logic                 p_valid_o,
    input  logic                 p_ready_i
);

    localparam int PtrWidth = $clog2(FifoDepth);
    localparam int CntWidth = PtrWidth + 1;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_DUAL = 3'd5,
        OP_ADD3 = 3'd6,
        OP_ILL  = 3'd7
    } op_e;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [4:0]           rd;
        logic [DataWidth-1:0] data0;
        logic [DataWidth-1:0] data1;
        logic                 dual;
        logic                 error;
    } resp_t;

    // Address and the opcode/upper instruction bits carry routing or decode info not used here.
    logic unused_inputs;
    assign unused_inputs = ^{q_addr_i, q_data_op_i[31:15], q_data_op_i[6:0]};

    op_e   op;
    resp_t req_resp;
    logic  accept;
    logic  pop;

    assign accept = q_valid_i && q_ready_o;
    assign pop    = p_valid_o && p_ready_i;

    // NOTE: every field gets a default before the case so no path leaves a latch behind.
    always_comb begin
        op             = op_e'(q_data_op_i[14:12]);
        req_resp       = '0;
        req_resp.id    = q_id_i;
        req_resp.rd    = q_data_op_i[11:7];
        case (op)
            OP_ADD:  req_resp.data0 = q_data_arga_i + q_data_argb_i;
            OP_SUB:  req_resp.data0 = q_data_arga_i - q_data_argb_i;
            OP_XOR:  req_resp.data0 = q_data_arga_i ^ q_data_argb_i;
            OP_AND:  req_resp.data0 = q_data_arga_i & q_data_argb_i;
            OP_OR:   req_resp.data0 = q_data_arga_i | q_data_argb_i;
            OP_DUAL: begin
                req_resp.data0 = q_data_arga_i + q_data_argb_i;
                req_resp.data1 = q_data_arga_i - q_data_argb_i;
                req_resp.dual  = 1'b1;
            end
            OP_ADD3: req_resp.data0 = q_data_arga_i + q_data_argb_i + q_data_argc_i;
            default: req_resp.error = 1'b1;
        endcase
    end

    // The FIFO write itself is the last pipeline stage, so Latency-1 explicit registers precede it.
    resp_t wr_data;
    logic  wr_en;

    generate
        if (Latency == 1) begin : g_direct
            assign wr_data = req_resp;
            assign wr_en   = accept;
        end else begin : g_pipe
            resp_t             stage_q [Latency-1];
            logic [Latency-2:0] stage_vld_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    stage_vld_q <= '0;
                    for (int i = 0; i < Latency - 1; i++) stage_q[i] <= '0;
                end else begin
                    stage_vld_q[0] <= accept;
                    stage_q[0]     <= req_resp;
                    for (int i = 1; i < Latency - 1; i++) begin
                        stage_vld_q[i] <= stage_vld_q[i-1];
                        stage_q[i]     <= stage_q[i-1];
                    end
                end
            end

            assign wr_data = stage_q[Latency-2];
            assign wr_en   = stage_vld_q[Latency-2];
        end
    endgenerate

    resp_t             mem_q [FifoDepth];
    logic [PtrWidth:0] wr_ptr_q;
    logic [PtrWidth:0] rd_ptr_q;
    logic [CntWidth-1:0] outstanding_q;

    // NOTE: the storage is reset too, so the p-channel data outputs read 0 straight after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q[PtrWidth-1:0]] <= wr_data;
                wr_ptr_q <= wr_ptr_q + (PtrWidth + 1)'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + (PtrWidth + 1)'(1);
        end
    end

    // Counting pipeline and FIFO occupancy together guarantees every FIFO write has a free slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding_q <= outstanding_q + CntWidth'(1);
                2'b01:   outstanding_q <= outstanding_q - CntWidth'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign q_ready_o = outstanding_q < CntWidth'(FifoDepth);
    assign p_valid_o = wr_ptr_q != rd_ptr_q;

    resp_t head;
    assign head               = mem_q[rd_ptr_q[PtrWidth-1:0]];
    assign p_data0_o          = head.data0;
    assign p_data1_o          = head.data1;
    assign p_dual_writeback_o = head.dual;
    assign p_id_o             = head.id;
    assign p_rd_o             = head.rd;
    assign p_error_o          = head.error;

endmodule

// File: tb/tb_acc_responder.sv
// Self-checking bench for acc_responder: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_acc_responder;

    localparam int Lat   = 2;
    localparam int Depth = 4;

    logic        clk_i;
    logic        rst_ni;
    logic [3:0]  q_addr_i;
    logic [3:0]  q_id_i;
    logic [31:0] q_data_op_i;
    logic [31:0] q_data_arga_i;
    logic [31:0] q_data_argb_i;
    logic [31:0] q_data_argc_i;
    logic        q_valid_i;
    logic        q_ready_o;
    logic [31:0] p_data0_o;
    logic [31:0] p_data1_o;
    logic        p_dual_writeback_o;
    logic [3:0]  p_id_o;
    logic [4:0]  p_rd_o;
    logic        p_error_o;
    logic        p_valid_o;
    logic        p_ready_i;

    acc_responder #(
        .DataWidth(32), .AddrWidth(4), .IdWidth(4), .Latency(Lat), .FifoDepth(Depth)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .q_addr_i           (q_addr_i),
        .q_id_i             (q_id_i),
        .q_data_op_i        (q_data_op_i),
        .q_data_arga_i      (q_data_arga_i),
        .q_data_argb_i      (q_data_argb_i),
        .q_data_argc_i      (q_data_argc_i),
        .q_valid_i          (q_valid_i),
        .q_ready_o          (q_ready_o),
        .p_data0_o          (p_data0_o),
        .p_data1_o          (p_data1_o),
        .p_dual_writeback_o (p_dual_writeback_o),
        .p_id_o             (p_id_o),
        .p_rd_o             (p_rd_o),
        .p_error_o          (p_error_o),
        .p_valid_o          (p_valid_o),
        .p_ready_i          (p_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        dual;
        logic        err;
        logic [3:0]  id;
        logic [4:0]  rd;
        int          avail;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;

    function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] c, input logic [3:0] id, input logic [4:0] rd);
        exp_t e;
        e.d0 = 32'd0; e.d1 = 32'd0; e.dual = 1'b0; e.err = 1'b0;
        e.id = id; e.rd = rd; e.avail = 0;
        case (f3)
            3'd0: e.d0 = a + b;
            3'd1: e.d0 = a - b;
            3'd2: e.d0 = a ^ b;
            3'd3: e.d0 = a & b;
            3'd4: e.d0 = a | b;
            3'd5: begin e.d0 = a + b; e.d1 = a - b; e.dual = 1'b1; end
            3'd6: e.d0 = a + b + c;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    always @(negedge rst_ni) exp_q.delete();

    always @(posedge clk_i) begin
        if (rst_ni) begin
            bit   ready_m, valid_m;
            exp_t e;
            ready_m = exp_q.size() < Depth;
            valid_m = exp_q.size() > 0 && exp_q[0].avail <= cyc;
            if (valid_m && p_ready_i) void'(exp_q.pop_front());
            if (q_valid_i && ready_m) begin
                e = model(q_data_op_i[14:12], q_data_arga_i, q_data_argb_i, q_data_argc_i,
                          q_id_i, q_data_op_i[11:7]);
                e.avail = cyc + Lat;
                exp_q.push_back(e);
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            check("rst_p_valid", p_valid_o, 0);
        end else begin
            bit exp_v;
            exp_v = exp_q.size() > 0 && exp_q[0].avail <= cyc;
            check("q_ready", q_ready_o, exp_q.size() < Depth);
            check("p_valid", p_valid_o, exp_v);
            if (exp_v && p_valid_o) begin
                check("p_data0", p_data0_o, exp_q[0].d0);
                check("p_data1", p_data1_o, exp_q[0].d1);
                check("p_dual",  p_dual_writeback_o, exp_q[0].dual);
                check("p_error", p_error_o, exp_q[0].err);
                check("p_id",    p_id_o, exp_q[0].id);
                check("p_rd",    p_rd_o, exp_q[0].rd);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [3:0] id, input logic [4:0] rd);
        logic [31:0] op;
        op           = 32'd0;
        op[14:12]    = f3;
        op[11:7]     = rd;
        op[6:0]      = 7'h2b;
        q_data_op_i  = op;
        q_addr_i     = 4'($urandom);
        q_id_i       = id;
        q_data_arga_i = a;
        q_data_argb_i = b;
        q_data_argc_i = c;
    endtask

    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [3:0] id, input logic [4:0] rd,
                        input bit keep);
        int n;
        bit r;
        n = 0;
        r = 1'b0;
        drive(f3, a, b, c, id, rd);
        q_valid_i = 1'b1;
        while (!r && n < 50) begin
            r = q_ready_o;
            @(posedge clk_i);
            n++;
        end
        check("send_accept", r, 1);
        #1;
        if (!keep) q_valid_i = 1'b0;
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        @(negedge clk_i);
        while (!p_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("resp_arrived", p_valid_o, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc, stalls, stale, cycles;
        bit r;

        rst_ni    = 1'b1;
        p_ready_i = 1'b1;
        q_valid_i = 1'b0;
        drive(3'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd0);
        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Reset release and first ADD: response in cycle 2 after the handshake cycle
        check("post_rst_q_ready", q_ready_o, 1);
        check("post_rst_p_valid", p_valid_o, 0);
        send(3'd0, 32'd5, 32'd7, 32'd0, 4'd3, 5'd10, 1'b0);
        @(negedge clk_i);
        check("add_cyc1_valid", p_valid_o, 0);
        @(negedge clk_i);
        check("add_cyc2_valid", p_valid_o, 1);
        check("add_data0", p_data0_o, 32'd12);
        check("add_id",    p_id_o, 4'd3);
        check("add_rd",    p_rd_o, 5'd10);
        check("add_error", p_error_o, 0);
        check("add_dual",  p_dual_writeback_o, 0);

        send(3'd1, 32'd0, 32'd1, 32'd0, 4'd4, 5'd1, 1'b0);
        wait_resp();
        check("sub_wrap_data0", p_data0_o, 32'hFFFF_FFFF);

        send(3'd5, 32'd9, 32'd4, 32'd0, 4'd5, 5'd2, 1'b0);
        wait_resp();
        check("dual_data0", p_data0_o, 32'd13);
        check("dual_data1", p_data1_o, 32'd5);
        check("dual_flag",  p_dual_writeback_o, 1);

        send(3'd6, 32'd1, 32'd2, 32'd3, 4'd6, 5'd3, 1'b0);
        wait_resp();
        check("add3_data0", p_data0_o, 32'd6);

        send(3'd7, 32'd3, 32'd4, 32'd5, 4'd1, 5'd7, 1'b0);
        wait_resp();
        check("ill_error", p_error_o, 1);
        check("ill_data0", p_data0_o, 32'd0);
        check("ill_data1", p_data1_o, 32'd0);
        check("ill_id",    p_id_o, 4'd1);
        repeat (4) @(posedge clk_i);
        #1;

        // Backpressure: only FifoDepth requests accepted, drained in order with stalls
        p_ready_i = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(3'd0, 32'(i), 32'd1, 32'd0, 4'(i), 5'(i));
            q_valid_i = 1'b1;
            r = q_ready_o;
            @(posedge clk_i);
            if (r) acc++;
            #1;
        end
        q_valid_i = 1'b0;
        check("bp_accepted", acc, 4);
        check("bp_q_ready_low", q_ready_o, 0);
        repeat (3) @(posedge clk_i);
        #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check("bp_valid", p_valid_o, 1);
            check("bp_id",    p_id_o, 4'(k));
            check("bp_data0", p_data0_o, 32'(k + 1));
            p_ready_i = 1'b1;
            @(posedge clk_i);
            #1;
            p_ready_i = 1'b0;
            if (k == 0) check("bp_q_ready_back", q_ready_o, 1);
        end
        p_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;

        // Streaming: random ops, random valid, no stalls expected
        acc = 0;
        stalls = 0;
        cycles = 0;
        while (acc < 100 && cycles < 1000) begin
            drive(3'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
                  $urandom, $urandom, 4'($urandom), 5'($urandom));
            q_valid_i = ($urandom_range(0, 3) != 0);
            r = q_ready_o;
            if (!r) stalls++;
            @(posedge clk_i);
            if (q_valid_i && r) acc++;
            #1;
            cycles++;
        end
        q_valid_i = 1'b0;
        check("stream_count", acc, 100);
        check("stream_stalls", stalls, 0);
        repeat (5) @(posedge clk_i);
        #1;

        // Reset mid-burst discards everything in flight
        p_ready_i = 1'b0;
        send(3'd0, 32'd1, 32'd1, 32'd0, 4'd10, 5'd1, 1'b1);
        send(3'd0, 32'd2, 32'd2, 32'd0, 4'd11, 5'd2, 1'b1);
        send(3'd0, 32'd3, 32'd3, 32'd0, 4'd12, 5'd3, 1'b0);
        check("pre_rst_p_valid", p_valid_o, 1);
        check("pre_rst_q_ready", q_ready_o, 1);
        rst_ni = 1'b0;
        #1;
        check("rst_imm_p_valid", p_valid_o, 0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        p_ready_i = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk_i);
            if (p_valid_o) stale++;
        end
        check("rst_no_stale", stale, 0);
        @(posedge clk_i);
        #1;
        send(3'd0, 32'd100, 32'd23, 32'd0, 4'd9, 5'd4, 1'b0);
        @(negedge clk_i);
        check("post_rst_cyc1_valid", p_valid_o, 0);
        @(negedge clk_i);
        check("post_rst_cyc2_valid", p_valid_o, 1);
        check("post_rst_data0", p_data0_o, 32'd123);
        check("post_rst_id", p_id_o, 4'd9);
        repeat (5) @(posedge clk_i);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
